// File: rtl/gray_host_if.sv
// gray_host_if: stores one raster-order gray image from pix_in_* and serves zero-latency reads on gray_req/gray_addr/gray_data until finish; req_count/proto_err report read activity and misuse
module gray_host_if #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_in_valid,
  input  logic [DATA_W-1:0] pix_in_data,
  output logic              pix_in_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              finish,
  output logic [15:0]       req_count,
  output logic              proto_err
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SERVE = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NPIX - 1);
  logic [1:0]        state;
  logic [ADDR_W:0]   wr_ptr;
  logic [DATA_W-1:0] mem [NPIX];
  assign pix_in_ready = state == LOAD;
  assign gray_ready   = state == SERVE;
  assign gray_data    = (gray_ready && gray_req) ? mem[gray_addr] : '0;
  always_ff @(posedge clk)
    if (reset && pix_in_ready && pix_in_valid) mem[wr_ptr[ADDR_W-1:0]] <= pix_in_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      req_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (gray_req && !gray_ready) proto_err <= 1'b1;
      case (state)
        IDLE, DONE: if (start) begin
          state     <= LOAD;
          wr_ptr    <= '0;
          req_count <= '0;
        end
        LOAD: if (pix_in_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST) state <= SERVE;
        end
        default: begin
          if (gray_req && req_count != 16'hFFFF) req_count <= req_count + 1'b1;
          if (finish) state <= DONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gray_host_if.sv
// tb_gray_host_if: randomized scoreboard bench for gray_host_if against an array image model
module tb_gray_host_if;
  localparam int N = 16384;
  logic clk = 0, reset = 0, start = 0, pix_in_valid = 0, gray_req = 0, finish = 0;
  logic [7:0] pix_in_data = 0;
  logic [13:0] gray_addr = 0;
  logic pix_in_ready, gray_ready, proto_err;
  logic [7:0] gray_data;
  logic [15:0] req_count;
  logic [7:0] model [N];
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0, ready_cnt = 0, exp_req = 0;
  gray_host_if dut (
    .clk(clk), .reset(reset), .start(start), .pix_in_valid(pix_in_valid),
    .pix_in_data(pix_in_data), .pix_in_ready(pix_in_ready), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .finish(finish), .req_count(req_count), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (pix_in_ready) ready_cnt++;
    if (gray_req) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL gray_data: unexpected request, got %0h expected none", gray_data);
      end else chk("gray_data", gray_data, exp_q.pop_front());
    end
  end
  task automatic read(int a, bit serving);
    gray_req = 1;
    gray_addr = 14'(a);
    exp_q.push_back(serving ? model[a] : 8'h00);
    if (serving && exp_req < 65535) exp_req++;
    tick;
    gray_req = 0;
  endtask
  task automatic load(int gap, bit rnd, int n);
    int acc = 0, cyc = 0, bad = 0;
    logic [7:0] d;
    bit v;
    start = 1;
    tick;
    start = 0;
    ready_cnt = 0;
    exp_req = 0;
    chk("ready_after_start", pix_in_ready, 1);
    while (acc < n) begin
      v = (cyc % gap) == gap - 1;
      d = rnd ? ((acc == N - 1) ? 8'hFF : 8'($urandom)) : 8'(acc);
      pix_in_valid = v;
      pix_in_data = d;
      if (!pix_in_ready || gray_ready) bad++;
      tick;
      if (v) begin
        model[acc] = d;
        acc++;
      end
      cyc++;
    end
    pix_in_valid = 0;
    chk("load_ready_levels", bad, 0);
    if (n == N) begin
      chk("gray_ready_rise", gray_ready, 1);
      chk("ready_fall", pix_in_ready, 0);
      chk("ready_cycles", ready_cnt, N * gap);
    end
  endtask
  task automatic rand_reads(int k);
    for (int i = 0; i < k; i++) begin
      pix_in_valid = 1'($urandom);
      pix_in_data = 8'($urandom);
      read(int'($urandom_range(N - 1)), 1);
    end
    pix_in_valid = 0;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_pix_ready"}, pix_in_ready, 0);
    chk({tag, "_gray_ready"}, gray_ready, 0);
    chk({tag, "_req_count"}, req_count, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
    chk({tag, "_gray_data"}, gray_data, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tick;
    tick;
    reset = 1;
    chk_reset("reset");
    read(5, 0);
    chk("idle_proto_err", proto_err, 1);
    chk("idle_req_count", req_count, 0);
    tick;
    tick;
    chk("proto_err_held", proto_err, 1);
    load(1, 0, 100);
    reset = 0;
    tick;
    reset = 1;
    chk_reset("midload");
    load(1, 0, N);
    foreach (model[i]) if (i < 3) model[i] = model[i];
    read(0, 1); read(1, 1); read(2, 1);
    read(128, 1); read(129, 1); read(130, 1);
    read(256, 1); read(257, 1); read(258, 1);
    chk("window_req_count", req_count, 9);
    rand_reads(20);
    read(N - 1, 1);
    read(0, 1);
    chk("serve_req_count", req_count, exp_req);
    finish = 1;
    read(300, 1);
    finish = 0;
    chk("finish_gray_ready", gray_ready, 0);
    chk("finish_req_count", req_count, exp_req);
    read(7, 0);
    chk("done_proto_err", proto_err, 1);
    chk("done_req_count", req_count, exp_req);
    load(3, 1, N);
    read(N - 1, 1);
    chk("last_pixel_ff", model[N - 1], 8'hFF);
    rand_reads(20);
    read(0, 1);
    chk("reload_req_count", req_count, exp_req);
    start = 1;
    finish = 1;
    tick;
    start = 0;
    finish = 0;
    chk("finish_wins_gray", gray_ready, 0);
    chk("finish_wins_pix", pix_in_ready, 0);
    tick;
    chk("done_stays", pix_in_ready, 0);
    tick;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
